// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master path (spi_controller <-> spi_shift_engine).
//  states_t  : shift engine FSM states
//  spi_cfg_t : per-transfer configuration latched on an accepted start
//  bit_pos   : maps the k-th transmitted/received bit to its position in the data word
package spi_pkg;

    localparam int unsigned SPI_DIV_W  = 8;
    localparam int unsigned SPI_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } states_t;

    typedef struct packed {
        logic                 lsb;
        logic                 bit8;
        logic                 cpol;
        logic                 cpha;
        logic [SPI_DIV_W-1:0] div;
    } spi_cfg_t;

    // Position in the word of the k-th bit on the wire, for either bit order and word size.
    function automatic logic [3:0] bit_pos(input logic [3:0] k, input logic lsb,
                                           input logic bit8);
        if (lsb) begin
            return k;
        end else if (bit8) begin
            return 4'd7 - k;
        end else begin
            return 4'd15 - k;
        end
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for the SPI shift engine.
//  clk  in  system clock
//  rst  in  asynchronous reset, active-high
//  en   in  count enable; while low the counter is held at zero
//  div  in  terminal count; tick fires every (div+1) enabled cycles
//  tick out one-cycle pulse on the last count of each half-period
module spi_clk_div #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    assign tick = en && (cnt_q == div);

    // Every state change of the engine happens on a tick, so wrapping to zero on the tick
    // also restarts the count on each state entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!en || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// Bit-level SPI master serializer.
//  Accepts one 8/16-bit word with its config, drives sclk/mosi/cs_n with the selected
//  CPOL/CPHA/bit order, samples miso and returns the received word with a done pulse.
// Ports:
//  clk, rst                 system clock, asynchronous active-high reset
//  start, tx_data           transfer request and word (sampled when accepted, busy=0)
//  cfg_lsb/8bit/cpol/cpha   bit order, word size, sclk idle level, sampling phase
//  cfg_div                  sclk half-period = cfg_div+1 clk cycles
//  busy, done, rx_data      transfer status, end-of-transfer pulse, received word
//  sclk, mosi, miso, cs_n   SPI pads
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W  = SPI_DIV_W,
    parameter int unsigned DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              cfg_lsb,
    input  logic              cfg_8bit,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    states_t           state_q, state_d;
    spi_cfg_t          cfg_q, cfg_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic [4:0]        edge_q, edge_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              cs_n_q, cs_n_d;

    logic              tick;
    logic              last_edge;
    logic [3:0]        bit_k;

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .div  (cfg_q.div),
        .tick (tick)
    );

    // Two sclk edges per bit: edge_q[0] is 0 on the leading edge, 1 on the trailing edge.
    assign bit_k     = edge_q[4:1];
    assign last_edge = (edge_q == (cfg_q.bit8 ? 5'd15 : 5'd31));

    always_comb begin
        state_d   = state_q;
        cfg_d     = cfg_q;
        tx_d      = tx_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        edge_d    = edge_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;

        unique case (state_q)
            IDLE: begin
                sclk_d = cfg_cpol;
                cs_n_d = 1'b1;
                // busy stays high through the done cycle so a start there is refused.
                if (done_q) begin
                    busy_d = 1'b0;
                end
                if (start && !busy_q) begin
                    cfg_d   = '{lsb: cfg_lsb, bit8: cfg_8bit, cpol: cfg_cpol, cpha: cfg_cpha,
                                div: cfg_div};
                    tx_d    = tx_data;
                    rx_sr_d = '0;
                    edge_d  = '0;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
                    state_d = SETUP;
                    // CPHA=0 needs the first bit valid before the first (sampling) edge.
                    if (!cfg_cpha) begin
                        mosi_d = tx_data[bit_pos(4'd0, cfg_lsb, cfg_8bit)];
                    end
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 5'd1;
                    if (edge_q[0] == cfg_q.cpha) begin
                        // Sampling edge: leading for CPHA=0, trailing for CPHA=1.
                        rx_sr_d[bit_pos(bit_k, cfg_q.lsb, cfg_q.bit8)] = miso;
                    end else if (cfg_q.cpha) begin
                        mosi_d = tx_q[bit_pos(bit_k, cfg_q.lsb, cfg_q.bit8)];
                    end else if (!last_edge) begin
                        mosi_d = tx_q[bit_pos(bit_k + 4'd1, cfg_q.lsb, cfg_q.bit8)];
                    end
                    if (last_edge) begin
                        edge_d  = '0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d   = IDLE;
                    cs_n_d    = 1'b1;
                    done_d    = 1'b1;
                    rx_data_d = cfg_q.bit8 ? {{(DATA_W-8){1'b0}}, rx_sr_q[7:0]} : rx_sr_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cfg_q     <= '0;
            tx_q      <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            edge_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            tx_q      <= tx_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            edge_q    <= edge_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: a cycle-level model derived from the transfer timing rules
// checks every output on every negedge; directed transfers pin the model with literals.
module tb_spi_shift_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] tx_data;
    logic        cfg_lsb, cfg_8bit, cfg_cpol, cfg_cpha;
    logic [7:0]  cfg_div;
    logic        busy, done;
    logic [15:0] rx_data;
    logic        sclk, mosi, miso, cs_n;
    logic        miso_loop, miso_val;

    int checks = 0;
    int errors = 0;

    assign miso = miso_loop ? mosi : miso_val;

    always #5 clk = ~clk;

    spi_shift_engine dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .tx_data  (tx_data),
        .cfg_lsb  (cfg_lsb),
        .cfg_8bit (cfg_8bit),
        .cfg_cpol (cfg_cpol),
        .cfg_cpha (cfg_cpha),
        .cfg_div  (cfg_div),
        .busy     (busy),
        .done     (done),
        .rx_data  (rx_data),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso),
        .cs_n     (cs_n)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    // A transfer occupies offsets t=1..D after the accepting edge, D=(2N+2)(div+1)+1.
    // Half-period h=(t-1)/(div+1): h=0 setup, h=1..2N shift, h=2N+1 hold; sclk edges
    // completed by offset t = clamp(h-1, 0, 2N).
    bit          m_active, m_lsb, m_b8, m_cpol, m_cpha, m_mosi, m_idle_sclk;
    int          m_t, m_d, m_n, m_div;
    logic [15:0] m_tx, m_rx_hold;
    bit          m_miso [1024];

    initial begin
        int   hp, edges, k, ts;
        bit   fin, e_mosi;
        logic [15:0] r;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_cs_n", cs_n, 1);
                chk("rst_sclk", sclk, 0);
                chk("rst_mosi", mosi, 0);
                chk("rst_rx", rx_data, 0);
                m_active = 0; m_mosi = 0; m_idle_sclk = 0; m_rx_hold = 0;
            end else if (m_active) begin
                hp    = (m_t - 1) / (m_div + 1);
                edges = hp - 1;
                if (edges < 0) edges = 0;
                if (edges > 2 * m_n) edges = 2 * m_n;
                if (!m_cpha) begin
                    k = edges / 2;
                    if (k > m_n - 1) k = m_n - 1;
                    e_mosi = m_tx[m_lsb ? k : m_n - 1 - k];
                end else if (edges == 0) begin
                    e_mosi = m_mosi;
                end else begin
                    k = (edges - 1) / 2;
                    e_mosi = m_tx[m_lsb ? k : m_n - 1 - k];
                end
                if (m_t < 1024) m_miso[m_t] = miso;
                fin = (m_t == m_d);
                if (fin) begin
                    r = '0;
                    for (int e = 0; e < 2 * m_n; e++) begin
                        if (((e % 2) == 0) == (m_cpha == 0)) begin
                            k  = e / 2;
                            ts = (e + 2) * (m_div + 1);
                            r[m_lsb ? k : m_n - 1 - k] = m_miso[ts];
                        end
                    end
                    m_rx_hold = r;
                end
                chk("m_busy", busy, 1);
                chk("m_done", done, fin);
                chk("m_cs_n", cs_n, fin);
                chk("m_sclk", sclk, m_cpol ^ edges[0]);
                chk("m_mosi", mosi, e_mosi);
                chk("m_rx", rx_data, m_rx_hold);
                m_mosi = e_mosi;
                if (fin) begin
                    m_active    = 0;
                    m_idle_sclk = cfg_cpol;
                end else begin
                    m_t++;
                end
            end else begin
                chk("m_idle_busy", busy, 0);
                chk("m_idle_done", done, 0);
                chk("m_idle_cs_n", cs_n, 1);
                chk("m_idle_sclk", sclk, m_idle_sclk);
                chk("m_idle_mosi", mosi, m_mosi);
                chk("m_idle_rx", rx_data, m_rx_hold);
                m_idle_sclk = cfg_cpol;
                if (start) begin
                    m_active = 1; m_t = 1;
                    m_lsb = cfg_lsb; m_b8 = cfg_8bit; m_cpol = cfg_cpol; m_cpha = cfg_cpha;
                    m_div = int'(cfg_div); m_tx = tx_data; m_n = cfg_8bit ? 8 : 16;
                    m_d = (2 * m_n + 2) * (m_div + 1) + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called just after an accepting edge; returns at the negedge of the done cycle.
    task automatic wait_done(input bit lat_cpol, input bit lat_cpha, input bit disturb,
                             input bit rnd, output int cyc, output logic [15:0] bits,
                             output int rises);
        logic prev;
        cyc = -1; bits = '0; rises = 0;
        prev = sclk;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (sclk !== prev) begin
                if (sclk === 1'b1) rises++;
                if ((sclk != lat_cpol) == (lat_cpha == 1'b0)) bits = {bits[14:0], mosi};
            end
            prev = sclk;
            if (done === 1'b1) begin
                cyc = k;
                return;
            end
            @(posedge clk);
            #2;
            if (disturb && k == 9) begin
                start = 1; cfg_cpol = ~cfg_cpol; cfg_cpha = ~cfg_cpha; cfg_lsb = ~cfg_lsb;
                cfg_8bit = ~cfg_8bit; cfg_div = 8'd5; tx_data = 16'hFFFF;
            end else if (disturb && k == 10) begin
                start = 0;
            end
            if (rnd) begin
                miso_val = 1'($urandom_range(0, 1));
                start    = 1'($urandom_range(0, 1));
                cfg_lsb  = 1'($urandom_range(0, 1));
                cfg_8bit = 1'($urandom_range(0, 1));
                cfg_cpol = 1'($urandom_range(0, 1));
                cfg_cpha = 1'($urandom_range(0, 1));
                cfg_div  = 8'($urandom);
                tx_data  = 16'($urandom);
            end
        end
        $display("FAIL timeout: no done within 3000 cycles");
    endtask

    task automatic run_xfer(input logic [15:0] tx, input bit lsb, input bit b8, input bit cpol,
                            input bit cpha, input logic [7:0] div, input bit loop,
                            input bit mval, input bit disturb, input bit rnd, input bit hold,
                            output int cyc, output logic [15:0] bits, output int rises);
        @(posedge clk);
        #2;
        tx_data = tx; cfg_lsb = lsb; cfg_8bit = b8; cfg_cpol = cpol; cfg_cpha = cpha;
        cfg_div = div; miso_loop = loop; miso_val = mval; start = 1;
        @(posedge clk);
        #2;
        if (!hold) begin
            start   = 0;
            tx_data = 16'($urandom);
        end
        wait_done(cpol, cpha, disturb, rnd, cyc, bits, rises);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          cyc, rises, n;
        logic [15:0] bits, tx;
        bit          lsb, b8, cpol, cpha, loop, mval;
        logic [7:0]  div;

        rst = 1; start = 0; tx_data = 0; cfg_lsb = 0; cfg_8bit = 0; cfg_cpol = 0;
        cfg_cpha = 0; cfg_div = 0; miso_loop = 0; miso_val = 0;
        repeat (3) @(posedge clk);
        #2;
        rst = 0;

        // 1: mode 0, MSB first, 8-bit, div=1, loopback
        run_xfer(16'h00A5, 0, 1, 0, 0, 8'd1, 1, 0, 0, 0, 0, cyc, bits, rises);
        chk("t1_latency", cyc, 37);
        chk("t1_rx", rx_data, 16'h00A5);
        chk("t1_mosi_bits", bits, 16'h00A5);
        chk("t1_sclk_pulses", rises, 8);

        // 2: mode 3, LSB first, 16-bit, div=0, miso tied high
        @(posedge clk);
        #2;
        cfg_cpol = 1;
        @(negedge clk);
        @(negedge clk);
        chk("t2_idle_sclk", sclk, 1);
        run_xfer(16'h1234, 1, 0, 1, 1, 8'd0, 0, 1, 0, 0, 0, cyc, bits, rises);
        chk("t2_latency", cyc, 35);
        chk("t2_rx", rx_data, 16'hFFFF);
        chk("t2_mosi_bits", bits, 16'h2C48);
        chk("t2_sclk_rises", rises, 16);

        // 3: 8-bit mode ignores the high byte; miso tied low
        run_xfer(16'hBEEF, 0, 1, 0, 0, 8'd1, 0, 0, 0, 0, 0, cyc, bits, rises);
        chk("t3_latency", cyc, 37);
        chk("t3_rx", rx_data, 16'h0000);
        chk("t3_mosi_bits", bits, 16'h00EF);
        chk("t3_sclk_pulses", rises, 8);

        // 4: start and cfg disturbed mid-transfer
        run_xfer(16'h003C, 0, 1, 0, 0, 8'd1, 1, 0, 1, 0, 0, cyc, bits, rises);
        chk("t4_latency", cyc, 37);
        chk("t4_rx", rx_data, 16'h003C);
        chk("t4_mosi_bits", bits, 16'h003C);

        // 5: reset during SHIFT, then a clean transfer
        @(posedge clk);
        #2;
        tx_data = 16'h00C3; cfg_lsb = 0; cfg_8bit = 1; cfg_cpol = 0; cfg_cpha = 0;
        cfg_div = 8'd1; miso_loop = 1; start = 1;
        @(posedge clk);
        #2;
        start = 0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1;
        @(negedge clk);
        chk("t5_cs_n", cs_n, 1);
        chk("t5_busy", busy, 0);
        chk("t5_sclk", sclk, 0);
        chk("t5_done", done, 0);
        chk("t5_rx", rx_data, 0);
        @(posedge clk);
        #2;
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_no_done", done, 0);
        end
        run_xfer(16'h00A5, 0, 1, 0, 0, 8'd1, 1, 0, 0, 0, 0, cyc, bits, rises);
        chk("t5_latency", cyc, 37);
        chk("t5_rx", rx_data, 16'h00A5);

        // 6: start held across done
        run_xfer(16'h005A, 0, 1, 0, 0, 8'd1, 1, 0, 0, 0, 1, cyc, bits, rises);
        chk("t6_latency_a", cyc, 37);
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("t6_gap_busy", busy, 0);
        chk("t6_gap_cs_n", cs_n, 1);
        @(posedge clk);
        #2;
        start = 0;
        wait_done(0, 0, 0, 0, cyc, bits, rises);
        chk("t6_latency_b", cyc, 37);
        chk("t6_rx", rx_data, 16'h005A);

        // Random transfers, checked by the model every cycle
        for (int i = 0; i < 40; i++) begin
            tx   = 16'($urandom);
            lsb  = 1'($urandom_range(0, 1));
            b8   = 1'($urandom_range(0, 1));
            cpol = 1'($urandom_range(0, 1));
            cpha = 1'($urandom_range(0, 1));
            div  = 8'($urandom_range(0, 3));
            loop = 1'($urandom_range(0, 1));
            mval = 1'($urandom_range(0, 1));
            start = 0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #2;
                cfg_cpol = 1'($urandom_range(0, 1));
                cfg_div  = 8'($urandom);
            end
            run_xfer(tx, lsb, b8, cpol, cpha, div, loop, mval, 0, 1, 0, cyc, bits, rises);
            n = b8 ? 8 : 16;
            chk("rand_latency", cyc, (2 * n + 2) * (int'(div) + 1) + 1);
            if (loop) chk("rand_loop_rx", rx_data, b8 ? {8'h00, tx[7:0]} : tx);
            start = 0;
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
